execute_muldiv: RTL and testbench
=================================

// Module: execute_muldiv
// PURPOSE
//  Parametrised EX stage: ALU path plus iterative multiply/divide unit with HI/LO registers.
//  Sits between decode and memory stages. Issues a pipeline stall when a HI/LO-dependent op meets a busy unit.
//  Unrelated ALU ops proceed while mul/div runs in the background.
// PARAMETERS
//  WIDTH     32  datapath width (even, >=8); HI/LO are WIDTH each
//  REG_AW    5   register-file address width
// PORTS
//  clk                 in   1       clock, all state updates on posedge
//  rst                 in   1       synchronous, active-high reset
//  alu_op_ex           in   4       ALU opcode (existing alu encoding)
//  md_op_ex            in   3       0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI/MTLO (imm_ex[0]: 0=HI,1=LO)
//  alu_a_sel_ex        in   1       1: A = zero-extended shamt imm_ex[10:6]; 0: reg_s_data_ex
//  alu_b_sel_ex        in   1       1: B = imm_ex; 0: reg_t_data_ex
//  imm_ex              in   WIDTH   extended immediate
//  mem_we_ex           in   1       memory write enable
//  reg_d_we_ex         in   1       destination register write enable
//  reg_d_addr_ex       in   REG_AW  destination register
//  reg_d_data_sel_ex   in   1       writeback source select (passed through)
//  reg_s_data_ex       in   WIDTH   rs operand
//  reg_t_data_ex       in   WIDTH   rt operand
//  stall_ex            out  1       combinational; 1 = hold IF/ID/EX inputs this cycle
//  md_busy             out  1       state != IDLE
//  alu_data_mem        out  WIDTH   ALU result, or HI/LO for MFHI/MFLO
//  reg_d_we_mem, reg_d_addr_mem, reg_d_data_sel_mem, reg_t_data_mem, mem_we_mem  out  registered copies
// BEHAVIOUR
//  Reset: all *_mem outputs 0, HI=LO=0, state IDLE, counter 0; reset beats any in-flight op (result discarded).
//  FSM: IDLE -> BUSY on accepted MULT/MULTU/DIV/DIVU; BUSY -> FIXUP on step with count==0; FIXUP -> IDLE.
//  Start (edge T0): latch |a|,|b| (magnitudes for signed ops, raw for unsigned), result-sign flags, count=WIDTH-1.
//  BUSY: one radix-2 step per cycle (shift-add multiply / restoring divide) on 2*WIDTH accumulator; WIDTH cycles.
//  FIXUP (edge T0+WIDTH+1): apply signs, write HI/LO. MULT: {HI,LO}=a*b (2*WIDTH product). DIV: LO=quotient,
//   HI=remainder; quotient truncates toward zero, remainder takes dividend sign.
//  Divide by zero: no trap; LO = all ones, HI = dividend (as supplied); still full latency.
//  Signed DIV of most-negative by -1: LO = most-negative, HI = 0.
//  stall_ex = (state != IDLE) && md_op_ex in {1..7}. Non-md ops never stall.
//  While stall_ex=1: bubble into MEM at next edge (reg_d_we_mem=0, mem_we_mem=0, other *_mem don't-care but
//   held); EX inputs are presumed held by upstream; no new md op accepted.
//  Accepted MFHI/MFLO: alu_data_mem <= HI/LO (post-update value) at next edge, reg_d fields pass through.
//  MTHI/MTLO (when IDLE): HI or LO <= reg_s_data_ex at next edge; reg_d_we_mem forced 0.
//  Otherwise alu_data_mem <= alu(opA,opB) with 1-cycle latency; all pass-through fields registered 1 cycle.
//  MFLO issued cycle after MULT: stalled exactly WIDTH+1 cycles, accepted at edge T0+WIDTH+2.
//  Start with md_op_ex held during stall restarts nothing: op is consumed once, when stall_ex=0.
// TESTING
//  1 Reset: assert rst 2 cycles mid-traffic -> all *_mem outputs 0, md_busy=0, MFHI/MFLO return 0.
//  2 MULT rs=-3 rt=5, then MFHI,MFLO -> stall_ex high 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//  3 DIVU 100/7 -> LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; MULTU 0xFFFFFFFF^2 -> HI=0xFFFFFFFE, LO=1.
//  4 DIV 0x80000000/0 -> LO=0xFFFFFFFF, HI=0x80000000; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  5 MULT then 10 ADD/ORI ops -> no stall, ALU results correct 1 cycle later; MFLO after 40 cycles -> no stall.
//  6 Reset at cycle 10 of DIV -> md_busy=0 next cycle, HI=LO=0, following MFLO returns 0 without stall.

Source files
------------

// File: rtl/execute_muldiv_if.sv
// execute_muldiv_if: EX-stage operand/control inputs and registered MEM-side outputs
interface execute_muldiv_if #(parameter int WIDTH = 32, parameter int REG_AW = 5);
  logic [3:0]        alu_op_ex;
  logic [2:0]        md_op_ex;
  logic              alu_a_sel_ex;
  logic              alu_b_sel_ex;
  logic [WIDTH-1:0]  imm_ex;
  logic              mem_we_ex;
  logic              reg_d_we_ex;
  logic [REG_AW-1:0] reg_d_addr_ex;
  logic              reg_d_data_sel_ex;
  logic [WIDTH-1:0]  reg_s_data_ex;
  logic [WIDTH-1:0]  reg_t_data_ex;
  logic              stall_ex;
  logic              md_busy;
  logic [WIDTH-1:0]  alu_data_mem;
  logic              reg_d_we_mem;
  logic [REG_AW-1:0] reg_d_addr_mem;
  logic              reg_d_data_sel_mem;
  logic [WIDTH-1:0]  reg_t_data_mem;
  logic              mem_we_mem;
  modport master (
    output alu_op_ex, md_op_ex, alu_a_sel_ex, alu_b_sel_ex, imm_ex, mem_we_ex, reg_d_we_ex,
           reg_d_addr_ex, reg_d_data_sel_ex, reg_s_data_ex, reg_t_data_ex,
    input  stall_ex, md_busy, alu_data_mem, reg_d_we_mem, reg_d_addr_mem, reg_d_data_sel_mem,
           reg_t_data_mem, mem_we_mem
  );
  modport slave (
    input  alu_op_ex, md_op_ex, alu_a_sel_ex, alu_b_sel_ex, imm_ex, mem_we_ex, reg_d_we_ex,
           reg_d_addr_ex, reg_d_data_sel_ex, reg_s_data_ex, reg_t_data_ex,
    output stall_ex, md_busy, alu_data_mem, reg_d_we_mem, reg_d_addr_mem, reg_d_data_sel_mem,
           reg_t_data_mem, mem_we_mem
  );
endinterface

// File: rtl/execute_muldiv.sv
// execute_muldiv: EX stage with 1-cycle ALU path and background iterative mul/div owning HI/LO
module execute_muldiv #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input logic             clk,
  input logic             rst,
  execute_muldiv_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, FIXUP} state_t;
  state_t              r_state;
  logic [SW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_dvd;
  logic                r_is_div;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_dz;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic [WIDTH-1:0]    r_alu_data;
  logic                r_reg_d_we;
  logic [REG_AW-1:0]   r_reg_d_addr;
  logic                r_reg_d_data_sel;
  logic [WIDTH-1:0]    r_reg_t_data;
  logic                r_mem_we;
  logic [2:0]          w_op;
  logic                w_stall;
  logic                w_start;
  logic                w_signed;
  logic                w_div;
  logic [WIDTH-1:0]    w_a;
  logic [WIDTH-1:0]    w_b;
  logic [WIDTH-1:0]    w_abs_a;
  logic [WIDTH-1:0]    w_abs_b;
  logic [WIDTH-1:0]    w_op_a;
  logic [WIDTH-1:0]    w_op_b;
  logic [SW-1:0]       w_shamt;
  logic [WIDTH-1:0]    w_alu;
  logic [WIDTH-1:0]    w_hi;
  logic [WIDTH:0]      w_msum;
  logic [WIDTH:0]      w_rem;
  logic [WIDTH:0]      w_diff;
  logic [2*WIDTH-1:0]  w_mul_next;
  logic [2*WIDTH-1:0]  w_div_next;
  logic [2*WIDTH-1:0]  w_prod;
  logic [WIDTH-1:0]    w_quo;
  logic [WIDTH-1:0]    w_rmd;
  assign w_op     = bus.md_op_ex;
  assign w_stall  = (r_state != IDLE) && (w_op != 3'd0);
  assign w_start  = (r_state == IDLE) && (w_op >= 3'd1) && (w_op <= 3'd4);
  assign w_signed = (w_op == 3'd1) || (w_op == 3'd3);
  assign w_div    = (w_op == 3'd3) || (w_op == 3'd4);
  assign w_a      = bus.reg_s_data_ex;
  assign w_b      = bus.reg_t_data_ex;
  assign w_abs_a  = (w_signed && w_a[WIDTH-1]) ? -w_a : w_a;
  assign w_abs_b  = (w_signed && w_b[WIDTH-1]) ? -w_b : w_b;
  assign w_op_a   = bus.alu_a_sel_ex ? {{(WIDTH-5){1'b0}}, bus.imm_ex[10:6]} : bus.reg_s_data_ex;
  assign w_op_b   = bus.alu_b_sel_ex ? bus.imm_ex : bus.reg_t_data_ex;
  assign w_shamt  = w_op_a[SW-1:0];
  always_comb begin
    w_alu = '0;
    case (bus.alu_op_ex)
      4'd0:    w_alu = w_op_a + w_op_b;
      4'd1:    w_alu = w_op_a - w_op_b;
      4'd2:    w_alu = w_op_a & w_op_b;
      4'd3:    w_alu = w_op_a | w_op_b;
      4'd4:    w_alu = w_op_a ^ w_op_b;
      4'd5:    w_alu = ~(w_op_a | w_op_b);
      4'd6:    w_alu = {{(WIDTH-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
      4'd7:    w_alu = {{(WIDTH-1){1'b0}}, w_op_a < w_op_b};
      4'd8:    w_alu = w_op_b << w_shamt;
      4'd9:    w_alu = w_op_b >> w_shamt;
      4'd10:   w_alu = $signed(w_op_b) >>> w_shamt;
      4'd11:   w_alu = w_op_b << (WIDTH / 2);
      default: w_alu = '0;
    endcase
  end
  // shift-add multiply: conditionally add multiplicand into upper half, then shift right
  assign w_hi       = r_acc[2*WIDTH-1:WIDTH];
  assign w_msum     = {1'b0, w_hi} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};
  // restoring divide: partial remainder in upper half, quotient bits shift into lower half
  assign w_rem      = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem - {1'b0, r_b};
  assign w_div_next = w_diff[WIDTH] ? {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_prod     = r_neg_q ? -r_acc : r_acc;
  assign w_quo      = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rmd      = r_neg_r ? -w_hi : w_hi;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_acc            <= '0;
      r_b              <= '0;
      r_dvd            <= '0;
      r_is_div         <= 1'b0;
      r_neg_q          <= 1'b0;
      r_neg_r          <= 1'b0;
      r_dz             <= 1'b0;
      r_hi             <= '0;
      r_lo             <= '0;
      r_alu_data       <= '0;
      r_reg_d_we       <= 1'b0;
      r_reg_d_addr     <= '0;
      r_reg_d_data_sel <= 1'b0;
      r_reg_t_data     <= '0;
      r_mem_we         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state  <= BUSY;
            r_cnt    <= SW'(WIDTH - 1);
            r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
            r_b      <= w_abs_b;
            r_dvd    <= w_a;
            r_is_div <= w_div;
            r_neg_q  <= w_signed && (w_a[WIDTH-1] ^ w_b[WIDTH-1]);
            r_neg_r  <= w_signed && w_div && w_a[WIDTH-1];
            r_dz     <= w_div && (w_b == '0);
          end
          if (w_op == 3'd7) begin
            if (bus.imm_ex[0]) r_lo <= w_a;
            else r_hi <= w_a;
          end
        end
        BUSY: begin
          r_acc   <= r_is_div ? w_div_next : w_mul_next;
          r_cnt   <= r_cnt - 1'b1;
          r_state <= (r_cnt == '0) ? FIXUP : BUSY;
        end
        FIXUP: begin
          r_state <= IDLE;
          if (r_is_div) begin
            r_hi <= r_dz ? r_dvd : w_rmd;
            r_lo <= r_dz ? '1 : w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_stall) begin
        r_reg_d_we <= 1'b0;
        r_mem_we   <= 1'b0;
      end else begin
        r_alu_data       <= (w_op == 3'd5) ? r_hi : (w_op == 3'd6) ? r_lo : w_alu;
        r_reg_d_we       <= (w_op == 3'd7) ? 1'b0 : bus.reg_d_we_ex;
        r_reg_d_addr     <= bus.reg_d_addr_ex;
        r_reg_d_data_sel <= bus.reg_d_data_sel_ex;
        r_reg_t_data     <= bus.reg_t_data_ex;
        r_mem_we         <= bus.mem_we_ex;
      end
    end
  end
  assign bus.stall_ex           = w_stall;
  assign bus.md_busy            = r_state != IDLE;
  assign bus.alu_data_mem       = r_alu_data;
  assign bus.reg_d_we_mem       = r_reg_d_we;
  assign bus.reg_d_addr_mem     = r_reg_d_addr;
  assign bus.reg_d_data_sel_mem = r_reg_d_data_sel;
  assign bus.reg_t_data_mem     = r_reg_t_data;
  assign bus.mem_we_mem         = r_mem_we;
endmodule

// File: tb/tb_execute_muldiv.sv
// tb_execute_muldiv: directed vectors for ALU path, mul/div results, stall timing and reset
module tb_execute_muldiv;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  execute_muldiv_if #(.WIDTH(W), .REG_AW(5)) bus ();
  execute_muldiv #(.WIDTH(W), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] md, input logic [3:0] alu, input logic [W-1:0] rs,
                       input logic [W-1:0] rt, input logic [W-1:0] imm, input logic asel,
                       input logic bsel, input logic we, input logic [4:0] addr);
    bus.md_op_ex          = md;
    bus.alu_op_ex         = alu;
    bus.reg_s_data_ex     = rs;
    bus.reg_t_data_ex     = rt;
    bus.imm_ex            = imm;
    bus.alu_a_sel_ex      = asel;
    bus.alu_b_sel_ex      = bsel;
    bus.reg_d_we_ex       = we;
    bus.reg_d_addr_ex     = addr;
    bus.reg_d_data_sel_ex = addr[0];
    bus.mem_we_ex         = 1'b0;
  endtask
  task automatic nop();
    drive(3'd0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask
  // issue op, follow immediately with MFHI (must stall W+1 cycles), then MFLO
  task automatic md_run(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo);
    int n;
    drive(op, 4'd0, a, b, '0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    drive(3'd5, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 5'd9);
    #1;
    n = 0;
    while (bus.stall_ex && n < 100) begin
      step();
      n++;
    end
    check({tag, "_stalls"}, n, W + 1);
    check({tag, "_bubble"}, bus.reg_d_we_mem, 1'b0);
    step();
    check({tag, "_hi"}, bus.alu_data_mem, hi);
    check({tag, "_hi_we"}, bus.reg_d_we_mem, 1'b1);
    drive(3'd6, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 5'd10);
    #1;
    check({tag, "_lo_nostall"}, bus.stall_ex, 1'b0);
    step();
    check({tag, "_lo"}, bus.alu_data_mem, lo);
  endtask
  task automatic read_hilo(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo);
    drive(3'd5, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 5'd3);
    #1;
    check({tag, "_hi_nostall"}, bus.stall_ex, 1'b0);
    step();
    check({tag, "_hi"}, bus.alu_data_mem, hi);
    drive(3'd6, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 5'd4);
    step();
    check({tag, "_lo"}, bus.alu_data_mem, lo);
  endtask
  initial begin
    logic [W-1:0] exp;
    nop();
    step();
    step();
    check("rst_alu", bus.alu_data_mem, '0);
    check("rst_we", bus.reg_d_we_mem, 1'b0);
    check("rst_busy", bus.md_busy, 1'b0);
    rst = 1'b0;
    // ALU path
    drive(3'd0, 4'd1, 32'd10, 32'd3, '0, 1'b0, 1'b0, 1'b1, 5'd1);
    bus.mem_we_ex = 1'b1;
    step();
    check("sub", bus.alu_data_mem, 32'd7);
    check("sub_memwe", bus.mem_we_mem, 1'b1);
    check("sub_tdata", bus.reg_t_data_mem, 32'd3);
    drive(3'd0, 4'd2, 32'h0000_F0F0, '0, 32'h0000_0FF0, 1'b0, 1'b1, 1'b1, 5'd2);
    step();
    check("andi", bus.alu_data_mem, 32'h0000_00F0);
    drive(3'd0, 4'd6, 32'hFFFF_FFFF, 32'd1, '0, 1'b0, 1'b0, 1'b1, 5'd3);
    step();
    check("slt", bus.alu_data_mem, 32'd1);
    drive(3'd0, 4'd8, '0, 32'd3, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 5'd4);
    step();
    check("sll", bus.alu_data_mem, 32'h0000_0030);
    drive(3'd0, 4'd10, '0, 32'h8000_0000, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 5'd5);
    step();
    check("sra", bus.alu_data_mem, 32'hF800_0000);
    // multiply / divide results
    md_run("mult", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    md_run("divu", 3'd4, 32'd100, 32'd7, 32'd2, 32'd14);
    md_run("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_run("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
    md_run("divz", 3'd3, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    md_run("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    // reset mid-traffic with a multiply in flight
    drive(3'd1, 4'd0, 32'd2, 32'd3, '0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    drive(3'd0, 4'd0, 32'd5, 32'd6, '0, 1'b0, 1'b0, 1'b1, 5'd7);
    bus.mem_we_ex = 1'b1;
    step();
    rst = 1'b1;
    step();
    step();
    check("rst2_alu", bus.alu_data_mem, '0);
    check("rst2_we", bus.reg_d_we_mem, 1'b0);
    check("rst2_addr", bus.reg_d_addr_mem, '0);
    check("rst2_tdata", bus.reg_t_data_mem, '0);
    check("rst2_memwe", bus.mem_we_mem, 1'b0);
    check("rst2_busy", bus.md_busy, 1'b0);
    rst = 1'b0;
    read_hilo("rst2", '0, '0);
    // ALU ops proceed while a multiply runs
    drive(3'd1, 4'd0, 32'd6, 32'd7, '0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        drive(3'd0, 4'd0, i * 3, 100 + i, '0, 1'b0, 1'b0, 1'b1, 5'(i));
        exp = i * 3 + 100 + i;
      end else begin
        drive(3'd0, 4'd3, i << 4, '0, 32'h100 + i, 1'b0, 1'b1, 1'b1, 5'(i));
        exp = (i << 4) | (32'h100 + i);
      end
      #1;
      check("bg_nostall", bus.stall_ex, 1'b0);
      step();
      check("bg_alu", bus.alu_data_mem, exp);
      check("bg_addr", bus.reg_d_addr_mem, i);
      check("bg_sel", bus.reg_d_data_sel_mem, i % 2);
    end
    nop();
    repeat (30) step();
    read_hilo("bg", '0, 32'd42);
    // MTHI / MTLO
    drive(3'd7, 4'd0, 32'h0000_CAFE, '0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1);
    step();
    check("mthi_we", bus.reg_d_we_mem, 1'b0);
    drive(3'd7, 4'd0, 32'h0000_BEEF, '0, 32'd1, 1'b0, 1'b0, 1'b1, 5'd1);
    step();
    read_hilo("mt", 32'h0000_CAFE, 32'h0000_BEEF);
    // reset at cycle 10 of a divide discards it
    drive(3'd3, 4'd0, 32'd100, 32'd7, '0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    nop();
    repeat (9) step();
    check("div_busy", bus.md_busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst3_busy", bus.md_busy, 1'b0);
    read_hilo("rst3", '0, '0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
